// File: rtl/color_ball_dispenser_pkg.sv
// Shared types for the colour ball dispenser: colour codes, FSM encoding,
// the six-entry R/B/G permutation table and a rotation helper.
package color_ball_pkg;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        BLUE  = 2'd1,
        GREEN = 2'd2
    } color_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        SEND1 = 3'd2,
        SEND2 = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam int unsigned NUM_PERMS = 6;
    localparam logic [2:0]  PERM_MAX  = 3'd5;

    // Each entry packs positions 0,1,2 from MSB to LSB, two bits per colour.
    localparam logic [5:0] PERM_TBL [NUM_PERMS] = '{
        {RED,   BLUE,  GREEN},
        {RED,   GREEN, BLUE },
        {BLUE,  RED,   GREEN},
        {BLUE,  GREEN, RED  },
        {GREEN, RED,   BLUE },
        {GREEN, BLUE,  RED  }
    };

    function automatic logic [2:0] next_perm(input logic [2:0] p);
        return (p >= PERM_MAX) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/color_ball_dispenser_if.sv
// Job request / ball stream bundle between a controller and the dispenser.
interface color_ball_dispenser_if #(
    parameter int SETS_W = 4
) ();
    logic              start;
    logic [2:0]        perm;
    logic [SETS_W-1:0] n_sets;
    logic              ready;
    logic [1:0]        ball;
    logic              valid;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, perm, n_sets, ready,
        input  ball, valid, busy, done, err
    );

    modport slave (
        input  start, perm, n_sets, ready,
        output ball, valid, busy, done, err
    );
endinterface

// File: rtl/color_ball_dispenser_perm_lut.sv
// Maps (permutation index, position within set) to a colour code.
module color_perm_lut
    import color_ball_pkg::*;
(
    input  logic [2:0] perm,
    input  logic [1:0] pos,
    output color_t     color
);
    logic [5:0] entry;

    // Out-of-range indices never reach here from the FSM; fall back to entry 0.
    always_comb begin
        entry = (perm <= PERM_MAX) ? PERM_TBL[perm] : PERM_TBL[0];
        case (pos)
            2'd0:    color = color_t'(entry[5:4]);
            2'd1:    color = color_t'(entry[3:2]);
            default: color = color_t'(entry[1:0]);
        endcase
    end
endmodule

// File: rtl/color_ball_dispenser.sv
// Colour ball dispenser: emits n_sets triplets of R/B/G in a chosen order,
// one ball per valid&ready transfer, optionally rotating the order per set.
//
// state | meaning
// IDLE  | waiting for start; start with perm>5 pulses err
// SEND0 | offering position 0 of the current permutation
// SEND1 | offering position 1
// SEND2 | offering position 2; transfer closes the set
// FIN   | one-cycle done pulse, then back to IDLE
module color_ball_dispenser
    import color_ball_pkg::*;
#(
    parameter int SETS_W = 4,
    parameter bit ROTATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    color_ball_dispenser_if.slave    bus
);
    state_t            state, nxt_state;
    logic [2:0]        perm_q, nxt_perm;
    logic [SETS_W-1:0] cnt_q, nxt_cnt;
    logic              nxt_err;
    logic              xfer;
    logic              nxt_send;
    logic [1:0]        nxt_pos;
    color_t            lut_color;

    // Next-state decode; outputs are then registered from the next state so
    // ball/valid are glitch-free and line up with the state they describe.
    always_comb begin
        nxt_state = state;
        nxt_perm  = perm_q;
        nxt_cnt   = cnt_q;
        nxt_err   = 1'b0;
        xfer      = bus.valid & bus.ready;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.perm > PERM_MAX) begin
                        nxt_err = 1'b1;
                    end else if (bus.n_sets == '0) begin
                        nxt_state = FIN;
                    end else begin
                        nxt_state = SEND0;
                        nxt_perm  = bus.perm;
                        nxt_cnt   = bus.n_sets;
                    end
                end
            end
            SEND0: if (xfer) nxt_state = SEND1;
            SEND1: if (xfer) nxt_state = SEND2;
            SEND2: begin
                if (xfer) begin
                    nxt_cnt = cnt_q - 1'b1;
                    if (cnt_q == SETS_W'(1)) begin
                        nxt_state = FIN;
                    end else begin
                        nxt_state = SEND0;
                        if (ROTATE) nxt_perm = next_perm(perm_q);
                    end
                end
            end
            FIN:     nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        nxt_send = (nxt_state == SEND0) || (nxt_state == SEND1) || (nxt_state == SEND2);
        case (nxt_state)
            SEND1:   nxt_pos = 2'd1;
            SEND2:   nxt_pos = 2'd2;
            default: nxt_pos = 2'd0;
        endcase
    end

    color_perm_lut u_lut (
        .perm  (nxt_perm),
        .pos   (nxt_pos),
        .color (lut_color)
    );

    // State, job context and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            perm_q    <= '0;
            cnt_q     <= '0;
            bus.ball  <= '0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            state     <= nxt_state;
            perm_q    <= nxt_perm;
            cnt_q     <= nxt_cnt;
            bus.ball  <= nxt_send ? lut_color : RED;
            bus.valid <= nxt_send;
            bus.busy  <= (nxt_state != IDLE);
            bus.done  <= (nxt_state == FIN);
            bus.err   <= nxt_err;
        end
    end
endmodule

// File: tb/tb_color_ball_dispenser.sv
// Directed bench for color_ball_dispenser: two instances (ROTATE=0 and
// ROTATE=1) share stimulus; vectors cover full jobs, hand sequences cover
// stalls, rejects, empty jobs, reset and start-while-busy.
module tb_color_ball_dispenser;

    typedef struct packed {
        logic [2:0]  perm;
        logic [3:0]  nsets;
        logic [11:0] e0;
        logic [11:0] e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    color_ball_dispenser_if #(.SETS_W(4)) if0 ();
    color_ball_dispenser_if #(.SETS_W(4)) if1 ();

    color_ball_dispenser #(.SETS_W(4), .ROTATE(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    color_ball_dispenser #(.SETS_W(4), .ROTATE(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] p, input logic [3:0] n, input logic r);
        if0.start = s; if0.perm = p; if0.n_sets = n; if0.ready = r;
        if1.start = s; if1.perm = p; if1.n_sets = n; if1.ready = r;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid0"}, int'(if0.valid), 0);
        chk({tag, "_busy0"},  int'(if0.busy),  0);
        chk({tag, "_ball0"},  int'(if0.ball),  0);
        chk({tag, "_done0"},  int'(if0.done),  0);
        chk({tag, "_err0"},   int'(if0.err),   0);
        chk({tag, "_valid1"}, int'(if1.valid), 0);
        chk({tag, "_busy1"},  int'(if1.busy),  0);
    endtask

    initial begin
        vec_t       v;
        logic [1:0] e0, e1;

        vecs[0] = '{perm: 3'd0, nsets: 4'd1, e0: 12'b000110_000000, e1: 12'b000110_000000};
        vecs[1] = '{perm: 3'd5, nsets: 4'd2, e0: 12'b100100_100100, e1: 12'b100100_000110};
        vecs[2] = '{perm: 3'd2, nsets: 4'd2, e0: 12'b010010_010010, e1: 12'b010010_011000};
        vecs[3] = '{perm: 3'd4, nsets: 4'd1, e0: 12'b100001_000000, e1: 12'b100001_000000};
        vecs[4] = '{perm: 3'd1, nsets: 4'd1, e0: 12'b001001_000000, e1: 12'b001001_000000};
        vecs[5] = '{perm: 3'd3, nsets: 4'd1, e0: 12'b011000_000000, e1: 12'b011000_000000};

        // Reset state
        rst = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        step();
        step();
        chk_quiet("reset");
        rst = 1'b0;
        step();
        chk_quiet("post_reset");

        // Full jobs with ready held high
        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            drive(1'b1, v.perm, v.nsets, 1'b1);
            step();
            drive(1'b0, v.perm, v.nsets, 1'b1);
            for (int i = 0; i < 3 * int'(v.nsets); i++) begin
                e0 = v.e0[11 - 2*i -: 2];
                e1 = v.e1[11 - 2*i -: 2];
                chk($sformatf("v%0d_b%0d_valid0", k, i), int'(if0.valid), 1);
                chk($sformatf("v%0d_b%0d_ball0", k, i),  int'(if0.ball),  int'(e0));
                chk($sformatf("v%0d_b%0d_valid1", k, i), int'(if1.valid), 1);
                chk($sformatf("v%0d_b%0d_ball1", k, i),  int'(if1.ball),  int'(e1));
                chk($sformatf("v%0d_b%0d_done0", k, i),  int'(if0.done),  0);
                chk($sformatf("v%0d_b%0d_done1", k, i),  int'(if1.done),  0);
                step();
            end
            chk($sformatf("v%0d_fin_done0", k),  int'(if0.done),  1);
            chk($sformatf("v%0d_fin_done1", k),  int'(if1.done),  1);
            chk($sformatf("v%0d_fin_valid0", k), int'(if0.valid), 0);
            chk($sformatf("v%0d_fin_ball0", k),  int'(if0.ball),  0);
            step();
            chk($sformatf("v%0d_end_done0", k),  int'(if0.done),  0);
            chk($sformatf("v%0d_end_busy0", k),  int'(if0.busy),  0);
            chk($sformatf("v%0d_end_busy1", k),  int'(if1.busy),  0);
        end

        // Stall in SEND1: perm 3 is B,G,R; G must hold while ready is low
        drive(1'b1, 3'd3, 4'd1, 1'b1);
        step();
        drive(1'b0, 3'd3, 4'd1, 1'b1);
        chk("stall_s0_ball", int'(if0.ball), 1);
        step();
        drive(1'b0, 3'd3, 4'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_hold%0d_valid", i), int'(if0.valid), 1);
            chk($sformatf("stall_hold%0d_ball", i),  int'(if0.ball),  2);
            step();
        end
        drive(1'b0, 3'd3, 4'd1, 1'b1);
        chk("stall_release_ball", int'(if0.ball), 2);
        step();
        chk("stall_s2_ball",  int'(if0.ball),  0);
        chk("stall_s2_valid", int'(if0.valid), 1);
        step();
        chk("stall_done", int'(if0.done), 1);
        step();
        chk("stall_idle_busy", int'(if0.busy), 0);

        // Rejected start (perm 6)
        drive(1'b1, 3'd6, 4'd2, 1'b1);
        step();
        drive(1'b0, 3'd0, 4'd0, 1'b1);
        chk("rej_err",   int'(if0.err),   1);
        chk("rej_busy",  int'(if0.busy),  0);
        chk("rej_valid", int'(if0.valid), 0);
        step();
        chk("rej_err_clr", int'(if0.err),   0);
        chk("rej_valid2",  int'(if0.valid), 0);
        chk("rej_busy2",   int'(if0.busy),  0);

        // Empty job: done next cycle, no ball
        drive(1'b1, 3'd0, 4'd0, 1'b1);
        step();
        drive(1'b0, 3'd0, 4'd0, 1'b1);
        chk("empty_done",  int'(if0.done),  1);
        chk("empty_valid", int'(if0.valid), 0);
        chk("empty_err",   int'(if0.err),   0);
        step();
        chk("empty_done_clr", int'(if0.done), 0);
        chk("empty_busy",     int'(if0.busy), 0);

        // Reset in SEND2 of set 1 of 3 aborts without done
        drive(1'b1, 3'd0, 4'd3, 1'b1);
        step();
        drive(1'b0, 3'd0, 4'd3, 1'b1);
        step();
        step();
        chk("abort_pre_ball", int'(if0.ball), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_valid", int'(if0.valid), 0);
        chk("abort_busy",  int'(if0.busy),  0);
        chk("abort_done",  int'(if0.done),  0);
        step();
        chk("abort_done2", int'(if0.done), 0);
        chk("abort_valid2", int'(if0.valid), 0);

        // Fresh job after abort: perm 1 is R,G,B
        drive(1'b1, 3'd1, 4'd1, 1'b1);
        step();
        drive(1'b0, 3'd1, 4'd1, 1'b1);
        chk("fresh_b0", int'(if0.ball), 0);
        step();
        chk("fresh_b1", int'(if0.ball), 2);
        step();
        chk("fresh_b2", int'(if0.ball), 1);
        step();
        chk("fresh_done", int'(if0.done), 1);
        step();

        // Reset together with start wins
        rst = 1'b1;
        drive(1'b1, 3'd0, 4'd1, 1'b1);
        step();
        rst = 1'b0;
        drive(1'b0, 3'd0, 4'd1, 1'b1);
        chk("rst_start_busy",  int'(if0.busy),  0);
        chk("rst_start_valid", int'(if0.valid), 0);
        step();
        chk("rst_start_busy2", int'(if0.busy), 0);

        // start with bad perm while busy is ignored
        drive(1'b1, 3'd0, 4'd1, 1'b1);
        step();
        chk("busy_s0_ball", int'(if0.ball), 0);
        drive(1'b1, 3'd6, 4'd5, 1'b1);
        step();
        chk("busy_err",  int'(if0.err),  0);
        chk("busy_ball", int'(if0.ball), 1);
        step();
        chk("busy_err2",  int'(if0.err),  0);
        chk("busy_ball2", int'(if0.ball), 2);
        drive(1'b0, 3'd0, 4'd0, 1'b1);
        step();
        chk("busy_done", int'(if0.done), 1);
        step();
        chk("busy_idle", int'(if0.busy), 0);
        chk("busy_idle_err", int'(if0.err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
